// File: rtl/mips_cpu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation encodings,
// FSM state encoding and the divider iteration count.
package mips_cpu_pkg;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } hilo_state_t;

endpackage

// File: rtl/mips_cpu_div_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step.
// load captures dividend/divisor and clears the step counter; last flags
// the step that produces the final quotient bit.
module mips_cpu_div_iter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Shift next dividend bit into the partial remainder and trial-subtract;
  // the extra top bit of diff is the borrow.
  always_comb begin
    trial = {remainder, quotient[WIDTH-1]};
    diff  = trial - {1'b0, divisor_q};
  end

  assign last = (count == CW'(WIDTH - 1));

  // Quotient register starts as the dividend and is shifted left each step,
  // so its top bit is always the next dividend bit to bring down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
      count     <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
      count     <= '0;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        remainder <= diff[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_muldiv.sv
// HI/LO register unit: MULT/MULTU (registered product, 2-cycle latency),
// DIV/DIVU (iterative restoring divider), MTHI/MTLO direct writes.
// Build option HILO_FWD_EN: forward MTHI/MTLO data onto hi/lo combinationally
// in the issuing cycle.
module mips_cpu_hilo_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  hilo_state_t state, state_next;
  hilo_op_t    op_e;

  logic is_mul, is_div, is_signed, div_zero;
  logic mt_hi, mt_lo;
  logic mul_load, div_load, div_step, write_mul, write_div;

  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH-1:0]   a_abs, b_abs, dividend_in;
  logic               neg_a, neg_b;
  logic               q_neg, r_neg, dz;

  logic [WIDTH-1:0]   quotient, remainder;
  logic               last;
  logic [WIDTH-1:0]   hi_div, lo_div;
  logic [WIDTH-1:0]   hi_q, lo_q;

  assign op_e      = hilo_op_t'(op);
  assign is_mul    = (op_e == OP_MULT) || (op_e == OP_MULTU);
  assign is_div    = (op_e == OP_DIV)  || (op_e == OP_DIVU);
  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign div_zero  = (b == '0);

  assign mt_hi = start && !busy && (op_e == OP_MTHI);
  assign mt_lo = start && !busy && (op_e == OP_MTLO);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control decode; busy is low only in IDLE/DONE, so a start
  // there is accepted
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mul_load   = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    write_mul  = 1'b0;
    write_div  = 1'b0;
    case (state)
      IDLE, DONE: begin
        done       = (state == DONE);
        state_next = IDLE;
        if (start && is_mul) begin
          mul_load   = 1'b1;
          state_next = MUL;
        end else if (start && is_div) begin
          div_load   = 1'b1;
          state_next = div_zero ? FIX : DIV;
        end
      end
      MUL: begin
        busy       = 1'b1;
        write_mul  = 1'b1;
        state_next = DONE;
      end
      DIV: begin
        busy     = 1'b1;
        div_step = 1'b1;
        if (last) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        write_div  = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign-extend or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the
  // product are then correct for both signed and unsigned multiply.
  always_comb begin
    mul_a = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    mul_b = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  end

  // Operand magnitudes for the unsigned divider
  always_comb begin
    neg_a       = is_signed && a[WIDTH-1];
    neg_b       = is_signed && b[WIDTH-1];
    a_abs       = neg_a ? -a : a;
    b_abs       = neg_b ? -b : b;
    dividend_in = div_zero ? a : a_abs;
  end

  // Product register and divide sign/zero flags captured at issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
    end else begin
      if (mul_load) prod <= mul_a * mul_b;
      if (div_load) begin
        q_neg <= neg_a ^ neg_b;
        r_neg <= neg_a;
        dz    <= div_zero;
      end
    end
  end

  mips_cpu_div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dividend_in),
    .divisor   (b_abs),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (last)
  );

  // Divide-by-zero skips all steps, so the quotient register still holds the
  // raw dividend loaded at issue and supplies hi directly.
  always_comb begin
    if (dz) begin
      lo_div = '1;
      hi_div = quotient;
    end else begin
      lo_div = q_neg ? -quotient  : quotient;
      hi_div = r_neg ? -remainder : remainder;
    end
  end

  // HI/LO registers: result writes, then MTHI/MTLO (never concurrent, since
  // result writes happen only while busy)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (write_mul) begin
      {hi_q, lo_q} <= prod;
    end else if (write_div) begin
      hi_q <= hi_div;
      lo_q <= lo_div;
    end else begin
      if (mt_hi) hi_q <= a;
      if (mt_lo) lo_q <= a;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = mt_hi ? a : hi_q;
  assign lo = mt_lo ? a : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Directed self-checking bench for mips_cpu_hilo_muldiv.
module tb_mips_cpu_hilo_muldiv;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd7;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_cpu_hilo_muldiv #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Present a request for one cycle; returns #1 after the accepting edge (cycle 1)
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
  endtask

  // Returns the cycle index (current cycle = 1) in which done is seen, 0 on timeout,
  // plus the number of busy cycles observed before it; ends at that negedge
  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 0; nbusy = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin cyc = k; return; end
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    int cyc, nb;
    #1 reset = 1'b1;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL rst_hi: got %h want 00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_lo: got %h want 00000000", lo); end
    @(posedge clk); #1 reset = 1'b0;
    issue(3'd4, 32'hAAAA5555, 32'h0);
    issue(3'd5, 32'h5555AAAA, 32'h0);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (9) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_div_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL midrst_hi: got %h want 00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL midrst_lo: got %h want 00000000", lo); end
    @(posedge clk); #1 reset = 1'b0;
    issue(3'd0, 32'd3, 32'd4);
    wait_done(cyc, nb);
    total++; if (cyc !== 2) begin bad++; $display("FAIL post_rst_mult_lat: got %0d want 2", cyc); end
    total++; if (hi !== 32'h0 || lo !== 32'd12) begin bad++; $display("FAIL post_rst_mult: got %h_%h want 00000000_0000000c", hi, lo); end
  endtask

  task automatic test_mult;
    int cyc, nb;
    @(posedge clk); #1;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_done(cyc, nb);
    total++; if (cyc !== 2 || nb !== 1) begin bad++; $display("FAIL mult_lat: got cyc=%0d busy=%0d want cyc=2 busy=1", cyc, nb); end
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult: got %h_%h want ffffffff_fffffffa", hi, lo); end
    @(posedge clk); #1;
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_done(cyc, nb);
    total++; if (cyc !== 2) begin bad++; $display("FAIL multu_lat: got %0d want 2", cyc); end
    total++; if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu: got %h_%h want 00000002_fffffffa", hi, lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_div;
    int cyc, nb;
    @(posedge clk); #1;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, nb);
    total++; if (cyc !== 34 || nb !== 33) begin bad++; $display("FAIL div_lat: got cyc=%0d busy=%0d want cyc=34 busy=33", cyc, nb); end
    total++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); end
    @(posedge clk); #1;
    issue(3'd3, 32'd7, 32'd2);
    wait_done(cyc, nb);
    total++; if (lo !== 32'd3 || hi !== 32'd1) begin bad++; $display("FAIL divu: got hi=%h lo=%h want hi=00000001 lo=00000003", hi, lo); end
    @(posedge clk); #1;
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    wait_done(cyc, nb);
    total++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin bad++; $display("FAIL div_negdivisor: got hi=%h lo=%h want hi=00000001 lo=fffffffd", hi, lo); end
  endtask

  task automatic test_div_edge;
    int cyc, nb;
    @(posedge clk); #1;
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, nb);
    total++; if (lo !== 32'h80000000 || hi !== 32'h0) begin bad++; $display("FAIL div_ovf: got hi=%h lo=%h want hi=00000000 lo=80000000", hi, lo); end
    @(posedge clk); #1;
    issue(3'd3, 32'd5, 32'd0);
    wait_done(cyc, nb);
    total++; if (cyc !== 2) begin bad++; $display("FAIL divu_zero_lat: got %0d want 2", cyc); end
    total++; if (hi !== 32'd5 || lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero: got hi=%h lo=%h want hi=00000005 lo=ffffffff", hi, lo); end
    @(posedge clk); #1;
    issue(3'd2, 32'hFFFFFFFB, 32'd0);
    wait_done(cyc, nb);
    total++; if (hi !== 32'hFFFFFFFB || lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_zero: got hi=%h lo=%h want hi=fffffffb lo=ffffffff", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int cyc, nb;
    @(posedge clk); #1;
    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(3'd0, 32'd5, 32'd6);
    wait_done(cyc, nb);
    total++; if (cyc !== 31) begin bad++; $display("FAIL busy_ignore_lat: got %0d want 31", cyc); end
    total++; if (lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL busy_ignore_res: got hi=%h lo=%h want hi=00000002 lo=0000000e", hi, lo); end
    issue(3'd1, 32'd5, 32'd6);
    wait_done(cyc, nb);
    total++; if (cyc !== 2) begin bad++; $display("FAIL b2b_lat: got %0d want 2", cyc); end
    total++; if (lo !== 32'd30 || hi !== 32'd0) begin bad++; $display("FAIL b2b_res: got hi=%h lo=%h want hi=00000000 lo=0000001e", hi, lo); end
  endtask

  task automatic test_mthi_mtlo;
    int cyc, nb;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'h1234; b = 32'h0;
    @(negedge clk);
`ifdef HILO_FWD_EN
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi_fwd: got %h want 00001234", hi); end
`else
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL mthi_nofwd: got %h want 00000000", hi); end
`endif
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi: got %h want 00001234", hi); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mthi_flags: got done=%b busy=%b want 0 0", done, busy); end
    @(posedge clk); #1;
    issue(3'd5, 32'h5678, 32'h0);
    total++; if (lo !== 32'h5678 || hi !== 32'h1234) begin bad++; $display("FAIL mtlo: got hi=%h lo=%h want hi=00001234 lo=00005678", hi, lo); end
    issue(3'd6, 32'hFFFF, 32'hFFFF);
    @(negedge clk);
    total++; if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL op6_noop: got hi=%h lo=%h busy=%b done=%b want 00001234 00005678 0 0", hi, lo, busy, done); end
    @(posedge clk); #1;
    issue(3'd3, 32'd7, 32'd2);
    issue(3'd5, 32'hDEAD, 32'h0);
    total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mtlo_busy: got %h want 00005678", lo); end
    wait_done(cyc, nb);
    total++; if (lo !== 32'd3 || hi !== 32'd1) begin bad++; $display("FAIL mtlo_busy_div: got hi=%h lo=%h want hi=00000001 lo=00000003", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_back_to_back();
    test_mthi_mtlo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
